// File: rtl/time_capture_writer.sv
// rtl/time_capture_writer.sv - triggered capture of decimated, scaled audio into the time-domain display RAM
// Arms after a holdoff, waits for a rising zero crossing (or a timeout) and writes one frame to RAM port A.
module time_capture_writer #(
  parameter int NUM_SAMPLES = 640,
  parameter int DECIM       = 4,
  parameter int SHIFT       = 8,
  parameter int CLAMP       = 120,
  parameter int HYST        = 8,
  parameter int TIMEOUT     = 4096,
  parameter int HOLDOFF     = 1000000
) (
  input  logic        ck100MHz,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  input  logic        freeze,
  output logic        enaTime,
  output logic        weaTime,
  output logic [9:0]  addraTime,
  output logic [7:0]  dinaTime,
  output logic        busy,
  output logic        frame_done,
  output logic        auto_trig
);

  localparam logic [1:0] stHoldoff  = 2'd0;
  localparam logic [1:0] stWaitLow  = 2'd1;
  localparam logic [1:0] stWaitRise = 2'd2;
  localparam logic [1:0] stCapture  = 2'd3;

  localparam logic [8:0]         DECIM_LAST = 9'(DECIM - 1);
  localparam logic [15:0]        TCNT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [19:0]        HCNT_LAST  = 20'(HOLDOFF - 1);
  localparam logic [9:0]         ADDR_LAST  = 10'(NUM_SAMPLES - 1);
  localparam logic signed [15:0] CLAMP_HI   = 16'(CLAMP);
  localparam logic signed [15:0] CLAMP_LO   = 16'(-CLAMP);
  localparam logic signed [7:0]  ARM_LEVEL  = 8'(-HYST);

  logic [1:0]         state;
  logic [8:0]         decimCnt;
  logic [15:0]        tcnt;
  logic [19:0]        hcnt;
  logic [9:0]         addr;
  logic               lastPending;
  logic               tick;
  logic signed [15:0] shifted;
  logic signed [7:0]  scaled;

  assign tick = sample_valid && (decimCnt == 9'd0);
  assign busy = (state != stHoldoff);

  always_comb begin
    shifted = $signed(sample) >>> SHIFT;
    scaled  = shifted[7:0];
    if (shifted > CLAMP_HI)
      scaled = CLAMP_HI[7:0];
    else if (shifted < CLAMP_LO)
      scaled = CLAMP_LO[7:0];
  end

  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      state       <= stHoldoff;
      decimCnt    <= 9'd0;
      tcnt        <= 16'd0;
      hcnt        <= 20'd0;
      addr        <= 10'd0;
      lastPending <= 1'b0;
      enaTime     <= 1'b0;
      weaTime     <= 1'b0;
      addraTime   <= 10'd0;
      dinaTime    <= 8'd0;
      frame_done  <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      enaTime     <= 1'b0;
      weaTime     <= 1'b0;
      frame_done  <= lastPending;
      lastPending <= 1'b0;

      // Free-running decimator keeps its phase even while idle
      if (sample_valid)
        decimCnt <= (decimCnt == DECIM_LAST) ? 9'd0 : decimCnt + 9'd1;

      case (state)
        stHoldoff: begin
          if (hcnt == HCNT_LAST) begin
            if (!freeze) begin
              state <= stWaitLow;
              tcnt  <= 16'd0;
              hcnt  <= 20'd0;
            end
          end else begin
            hcnt <= hcnt + 20'd1;
          end
        end

        stWaitLow, stWaitRise: begin
          if (tick) begin
            // A real trigger wins over a simultaneous timeout
            if ((state == stWaitRise && !scaled[7]) || (tcnt == TCNT_LAST)) begin
              auto_trig <= !(state == stWaitRise && !scaled[7]);
              enaTime   <= 1'b1;
              weaTime   <= 1'b1;
              addraTime <= 10'd0;
              dinaTime  <= scaled;
              addr      <= 10'd1;
              tcnt      <= 16'd0;
              state     <= stCapture;
            end else begin
              tcnt <= tcnt + 16'd1;
              if (state == stWaitLow && scaled < ARM_LEVEL)
                state <= stWaitRise;
            end
          end
        end

        stCapture: begin
          if (tick) begin
            enaTime   <= 1'b1;
            weaTime   <= 1'b1;
            addraTime <= addr;
            dinaTime  <= scaled;
            if (addr == ADDR_LAST) begin
              addr        <= 10'd0;
              hcnt        <= 20'd0;
              lastPending <= 1'b1;
              state       <= stHoldoff;
            end else begin
              addr <= addr + 10'd1;
            end
          end
        end

        default: state <= stHoldoff;
      endcase
    end
  end

endmodule
